// File: rtl/jump_arc_ctrl.sv
// Per-fighter vertical jump controller: symmetric gravity arc with apex hang and landing
// recovery, producing a registered signed Y delta that always sums back to ground height.
module jump_arc_ctrl #(
  parameter int unsigned JUMP_V0     = 8,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned HANG_FRAMES = 2,
  parameter int unsigned LAND_FRAMES = 4
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       Jump,
  output logic [9:0] Y_Motion,
  output logic       Jmp,
  output logic [9:0] Height,
  output logic       Apex
);

  localparam logic [4:0] V0     = 5'(JUMP_V0);
  localparam logic [4:0] Grav   = 5'(GRAVITY);
  localparam logic [3:0] HangLd = (HANG_FRAMES == 0) ? 4'd0 : 4'(HANG_FRAMES - 1);
  localparam logic [3:0] LandLd = (LAND_FRAMES == 0) ? 4'd0 : 4'(LAND_FRAMES - 1);

  typedef enum logic [2:0] {StIdle, StAscend, StHang, StDescend, StLand} state_e;

  state_e     state_q, state_d;
  logic [4:0] vel_q, vel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic [9:0] y_q, y_d;
  logic       jmp_q, jmp_d;
  logic [9:0] height_q, height_d;
  logic       apex_q, apex_d;

  logic [5:0] vel_sum;
  logic [4:0] vel_inc;

  // Downward step limited to the height left once the pending motion has been applied.
  function automatic logic [9:0] clamp_step(input logic [4:0] v, input logic [9:0] rem);
    return (rem < {5'd0, v}) ? rem : {5'd0, v};
  endfunction

  always_comb begin
    vel_sum  = {1'b0, vel_q} + {1'b0, Grav};
    vel_inc  = vel_sum[5] ? 5'd31 : vel_sum[4:0];
    state_d  = state_q;
    vel_d    = vel_q;
    cnt_d    = cnt_q;
    y_d      = '0;
    apex_d   = 1'b0;
    jmp_d    = jmp_q;
    height_d = height_q - y_q;
    armed_d  = armed_q | ~Jump;

    unique case (state_q)
      StIdle: begin
        jmp_d = 1'b0;
        if (Jump && armed_q) begin
          state_d = StAscend;
          vel_d   = V0;
          y_d     = -{5'd0, V0};
          jmp_d   = 1'b1;
          armed_d = 1'b0;
        end
      end
      StAscend: begin
        vel_d = vel_q - Grav;
        if (vel_q > Grav) begin
          y_d = -{5'd0, vel_d};
        end else if (HANG_FRAMES != 0) begin
          state_d = StHang;
          apex_d  = 1'b1;
          cnt_d   = HangLd;
        end else begin
          state_d = StDescend;
          vel_d   = Grav;
          y_d     = clamp_step(Grav, height_d);
        end
      end
      StHang: begin
        if (cnt_q == 4'd0) begin
          state_d = StDescend;
          vel_d   = Grav;
          y_d     = clamp_step(Grav, height_d);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDescend: begin
        if (height_d == 10'd0) begin
          if (LAND_FRAMES != 0) begin
            state_d = StLand;
            cnt_d   = LandLd;
          end else begin
            state_d = StIdle;
            jmp_d   = 1'b0;
          end
        end else begin
          vel_d = vel_inc;
          y_d   = clamp_step(vel_inc, height_d);
        end
      end
      StLand: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          jmp_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        jmp_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      vel_q    <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      y_q      <= '0;
      jmp_q    <= 1'b0;
      height_q <= '0;
      apex_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vel_q    <= vel_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      y_q      <= y_d;
      jmp_q    <= jmp_d;
      height_q <= height_d;
      apex_q   <= apex_d;
    end
  end

  assign Y_Motion = y_q;
  assign Jmp      = jmp_q;
  assign Height   = height_q;
  assign Apex     = apex_q;

endmodule

// File: tb/tb_jump_arc_ctrl.sv
// Directed bench for jump_arc_ctrl: three parameterisations driven from vector tables
// plus hand-written sequences for held keys, async reset and the long no-hang arc.
module tb_jump_arc_ctrl;

  typedef struct {
    logic        jump;
    int          y;
    logic        jmp;
    int          h;
    logic        apex;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       jump_a, jump_b, jump_c;
  logic [9:0] ya, yb, yc, ha, hb, hc;
  logic       jmpa, jmpb, jmpc, apa, apb, apc;

  logic [9:0] oy, oh;
  logic       ojmp, oap;
  int         sel;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tab[$];

  always #5 clk = ~clk;

  jump_arc_ctrl dut_a (
    .frame_clk(clk), .Reset_n(rst_n), .Jump(jump_a),
    .Y_Motion(ya), .Jmp(jmpa), .Height(ha), .Apex(apa)
  );

  jump_arc_ctrl #(.JUMP_V0(8), .GRAVITY(3), .HANG_FRAMES(2), .LAND_FRAMES(4)) dut_b (
    .frame_clk(clk), .Reset_n(rst_n), .Jump(jump_b),
    .Y_Motion(yb), .Jmp(jmpb), .Height(hb), .Apex(apb)
  );

  jump_arc_ctrl #(.JUMP_V0(31), .GRAVITY(1), .HANG_FRAMES(0), .LAND_FRAMES(0)) dut_c (
    .frame_clk(clk), .Reset_n(rst_n), .Jump(jump_c),
    .Y_Motion(yc), .Jmp(jmpc), .Height(hc), .Apex(apc)
  );

  always_comb begin
    oy = ya; oh = ha; ojmp = jmpa; oap = apa;
    case (sel)
      1: begin oy = yb; oh = hb; ojmp = jmpb; oap = apb; end
      2: begin oy = yc; oh = hc; ojmp = jmpc; oap = apc; end
      default: ;
    endcase
  end

  function automatic vec_t mk(logic j, int y, logic jm, int h, logic ap);
    vec_t v;
    v.jump = j; v.y = y; v.jmp = jm; v.h = h; v.apex = ap;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_jump(input int which, input logic v);
    case (which)
      1: jump_b = v;
      2: jump_c = v;
      default: jump_a = v;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic run_tab(input int which, input string tag);
    int ay;
    sel = which;
    for (int i = 0; i < tab.size(); i++) begin
      set_jump(which, tab[i].jump);
      step();
      ay = int'($signed(oy));
      n_vec++;
      if (ay != tab[i].y || ojmp != tab[i].jmp || int'(oh) != tab[i].h || oap != tab[i].apex) begin
        n_err++;
        $display("FAIL %s[%0d]: got y=%0d jmp=%0b h=%0d apex=%0b, expected y=%0d jmp=%0b h=%0d apex=%0b",
                 tag, i, ay, ojmp, oh, oap, tab[i].y, tab[i].jmp, tab[i].h, tab[i].apex);
      end
    end
    set_jump(which, 1'b0);
  endtask

  task automatic fill_basic();
    tab.delete();
    tab.push_back(mk(1, -8, 1,  0, 0));
    tab.push_back(mk(0, -7, 1,  8, 0));
    tab.push_back(mk(0, -6, 1, 15, 0));
    tab.push_back(mk(0, -5, 1, 21, 0));
    tab.push_back(mk(0, -4, 1, 26, 0));
    tab.push_back(mk(0, -3, 1, 30, 0));
    tab.push_back(mk(0, -2, 1, 33, 0));
    tab.push_back(mk(0, -1, 1, 35, 0));
    tab.push_back(mk(0,  0, 1, 36, 1));
    tab.push_back(mk(0,  0, 1, 36, 0));
    tab.push_back(mk(0,  1, 1, 36, 0));
    tab.push_back(mk(0,  2, 1, 35, 0));
    tab.push_back(mk(0,  3, 1, 33, 0));
    tab.push_back(mk(0,  4, 1, 30, 0));
    tab.push_back(mk(0,  5, 1, 26, 0));
    tab.push_back(mk(0,  6, 1, 21, 0));
    tab.push_back(mk(0,  7, 1, 15, 0));
    tab.push_back(mk(0,  8, 1,  8, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 0,  0, 0));
  endtask

  initial begin
    int cnt, rises, prev, frames, peak, sum, miny, zeroes;
    rst_n = 1'b0; jump_a = 1'b0; jump_b = 1'b0; jump_c = 1'b0; sel = 0;
    #12;
    chk("reset a", int'({ya, jmpa, ha, apa}), 0);
    chk("reset b", int'({yb, jmpb, hb, apb}), 0);
    chk("reset c", int'({yc, jmpc, hc, apc}), 0);
    rst_n = 1'b1;
    step();

    // Basic arc, single-frame press.
    fill_basic();
    run_tab(0, "t1");
    idle(2);

    // Held key: one jump only, then release-and-press re-triggers.
    sel = 0;
    jump_a = 1'b1;
    cnt = 0; rises = 0; prev = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (jmpa) cnt++;
      if (jmpa && prev == 0) rises++;
      prev = int'(jmpa);
    end
    chk("t2 jmp frames", cnt, 22);
    chk("t2 jump count", rises, 1);
    jump_a = 1'b0;
    step();
    jump_a = 1'b1;
    step();
    chk("t2 retrigger y", int'($signed(ya)), -8);
    jump_a = 1'b0;
    idle(30);

    // Coarse gravity, clamped final descent step.
    tab.delete();
    tab.push_back(mk(1, -8, 1,  0, 0));
    tab.push_back(mk(0, -5, 1,  8, 0));
    tab.push_back(mk(0, -2, 1, 13, 0));
    tab.push_back(mk(0,  0, 1, 15, 1));
    tab.push_back(mk(0,  0, 1, 15, 0));
    tab.push_back(mk(0,  3, 1, 15, 0));
    tab.push_back(mk(0,  6, 1, 12, 0));
    tab.push_back(mk(0,  6, 1,  6, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 1,  0, 0));
    tab.push_back(mk(0,  0, 0,  0, 0));
    run_tab(1, "t3");
    idle(2);

    // Async reset mid-ascent.
    sel = 0;
    jump_a = 1'b1;
    step();
    jump_a = 1'b0;
    idle(3);
    chk("t4 pre-reset y", int'($signed(ya)), -5);
    #2 rst_n = 1'b0;
    #1 chk("t4 async reset", int'({ya, jmpa, ha, apa}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    jump_a = 1'b1;
    step();
    chk("t4 fresh arc y", int'($signed(ya)), -8);
    chk("t4 fresh arc h", int'(ha), 0);
    jump_a = 1'b0;
    idle(30);

    // Re-presses during hang and landing are ignored; press after idle starts a new jump.
    fill_basic();
    tab[9].jump  = 1'b1;
    tab[19].jump = 1'b1;
    tab.push_back(mk(1, -8, 1, 0, 0));
    run_tab(0, "t5");
    idle(30);

    // Maximum arc, no hang or land frames.
    sel = 2;
    jump_c = 1'b1;
    step();
    jump_c = 1'b0;
    frames = 0; peak = 0; sum = 0; miny = 0; zeroes = 0;
    for (int k = 0; k < 200 && jmpc; k++) begin
      frames++;
      sum += int'($signed(yc));
      if (int'(hc) > peak) peak = int'(hc);
      if (int'($signed(yc)) < miny) miny = int'($signed(yc));
      if (yc == 10'd0) zeroes++;
      step();
    end
    chk("t6 jump ended", int'(jmpc), 0);
    chk("t6 jmp frames", frames, 62);
    chk("t6 peak height", peak, 496);
    chk("t6 y sum", sum, 0);
    chk("t6 min y", miny, -31);
    chk("t6 zero frames", zeroes, 0);
    chk("t6 final height", int'(hc), 0);
    chk("t6 final y", int'(yc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
